// File: rtl/ed25519_pkg.sv
// Shared field constants and FSM encoding for the Ed25519 point pipeline.
// The field-multiplier reduction helper lives here as well.
package ed25519_pkg;

    // p = 2^255 - 19 and p - 2, written as complements of small constants
    localparam logic [254:0] P_MOD   = ~255'd18;
    localparam logic [254:0] E_INV   = ~255'd20;
    localparam logic [254:0] FE_ZERO = '0;
    localparam logic [254:0] FE_ONE  = 255'd1;

    localparam int DIG_W = 32;
    localparam int N_DIG = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SQR,
        ST_MUL,
        ST_AFFX,
        ST_AFFY,
        ST_PACK,
        ST_FIN
    } state_t;

    // Reduce v < 2^288 to [0,p) using 2^255 == 19 (mod p), folded twice.
    function automatic logic [254:0] fe_fold(input logic [287:0] v);
        logic [255:0] s1;
        logic [254:0] s2;
        logic [255:0] d;
        s1 = {1'b0, v[254:0]} + 256'(v[287:255]) * 256'd19;
        s2 = s1[254:0] + (s1[255] ? 255'd19 : 255'd0);
        d  = {1'b0, s2} - {1'b0, P_MOD};
        return d[255] ? s2 : d[254:0];
    endfunction

endpackage

// File: rtl/fe_mul_25519.sv
// Digit-serial modular multiplier over GF(2^255-19): 32 bits of b per cycle, MSB first.
// Fixed latency of N_DIG cycles after start; done is a one-cycle pulse.
module fe_mul_25519
    import ed25519_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic [254:0] res,
    output logic         done,
    output logic         busy
);

    logic [254:0] op_a;
    logic [255:0] op_b;
    logic [254:0] acc;
    logic [2:0]   cnt;
    logic         run;
    logic [287:0] step;

    // Horner step: acc*2^32 + a*digit stays below 2^288, so one fold suffices
    assign step = {1'b0, acc, {DIG_W{1'b0}}} + 288'(op_a) * 288'(op_b[255 -: DIG_W]);
    assign busy = run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a <= '0;
            op_b <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            res  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!run) begin
                if (start) begin
                    op_a <= a;
                    op_b <= {1'b0, b};
                    acc  <= '0;
                    cnt  <= 3'(N_DIG - 1);
                    run  <= 1'b1;
                end
            end else begin
                acc  <= fe_fold(step);
                op_b <= op_b << DIG_W;
                if (cnt == 3'd0) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                    res  <= fe_fold(step);
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/point_encode_25519.sv
// Converts an extended-projective Ed25519 point to its 256-bit RFC 8032 encoding.
// Constant-time Fermat inversion of Z followed by two affine multiplies.
//
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | flag Z == 0
//   SQR     | acc <= acc^2
//   MUL     | t <= acc*Z, keep t or acc by exponent bit
//   AFFX    | x <= X * Z^-1
//   AFFY    | y <= Y * Z^-1
//   PACK    | enc <= {x[0], y} or zero with err
//   FIN     | done pulse
module point_encode_25519
    import ed25519_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] in_x,
    input  logic [254:0] in_y,
    input  logic [254:0] in_z,
    output logic [255:0] enc,
    output logic         err,
    output logic         done,
    output logic         busy
);

    state_t       state, state_nx;
    logic [254:0] acc, reg_x, reg_y, reg_z;
    logic [7:0]   idx;
    logic         z_zero;
    logic         mul_pend;
    logic         mul_start, mul_done, mul_busy;
    logic [254:0] mul_a, mul_b, mul_res;
    logic         mul_state;

    fe_mul_25519 u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .res   (mul_res),
        .done  (mul_done),
        .busy  (mul_busy)
    );

    assign mul_state = (state == ST_SQR) || (state == ST_MUL) ||
                       (state == ST_AFFX) || (state == ST_AFFY);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    always_comb begin
        state_nx  = state;
        mul_a     = acc;
        mul_b     = acc;
        mul_start = mul_state && !mul_pend && !mul_busy;
        case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_SQR;
            ST_SQR:  if (mul_done) state_nx = ST_MUL;
            ST_MUL: begin
                mul_b = reg_z;
                if (mul_done) state_nx = (idx == 8'd0) ? ST_AFFX : ST_SQR;
            end
            ST_AFFX: begin
                mul_a = reg_x;
                if (mul_done) state_nx = ST_AFFY;
            end
            ST_AFFY: begin
                mul_a = reg_y;
                if (mul_done) state_nx = ST_PACK;
            end
            ST_PACK: state_nx = ST_FIN;
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            reg_x    <= '0;
            reg_y    <= '0;
            reg_z    <= '0;
            idx      <= '0;
            z_zero   <= 1'b0;
            mul_pend <= 1'b0;
            enc      <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            if (mul_start) mul_pend <= 1'b1;
            if (mul_done)  mul_pend <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    reg_x <= in_x;
                    reg_y <= in_y;
                    reg_z <= in_z;
                    acc   <= FE_ONE;
                    idx   <= 8'd254;
                    err   <= 1'b0;
                end
                ST_LOAD: z_zero <= (reg_z == FE_ZERO);
                ST_SQR:  if (mul_done) acc <= mul_res;
                ST_MUL:  if (mul_done) begin
                    // the product is always computed; the exponent bit only steers the mux
                    acc <= E_INV[idx] ? mul_res : acc;
                    if (idx != 8'd0) idx <= idx - 8'd1;
                end
                ST_AFFX: if (mul_done) reg_x <= mul_res;
                ST_AFFY: if (mul_done) reg_y <= mul_res;
                ST_PACK: begin
                    enc <= z_zero ? '0 : {reg_x[0], reg_y};
                    err <= z_zero;
                end
                default: ;
            endcase
        end
    end

endmodule
